// File: rtl/clint_timer_pkg.sv
// Shared constants for the core-local interruptor: register offsets, time width, reset values.
package clint_timer_pkg;

    localparam int unsigned TIME_W = 64;
    localparam int unsigned REG_W  = 32;
    localparam int unsigned OFFS_W = 16;

    localparam logic RESET_ENABLE = 1'b1;

    localparam logic [OFFS_W-1:0] CLINT_MSIP        = 16'h0000;
    localparam logic [OFFS_W-1:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [OFFS_W-1:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [OFFS_W-1:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [OFFS_W-1:0] CLINT_MTIME_HI    = 16'hBFFC;

    // All-ones compare value keeps the timer interrupt quiet out of reset
    localparam logic [TIME_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI
    } reg_sel_e;

endpackage

// File: rtl/clint_prescaler.sv
// Divides clk_i down to the mtime increment strobe: tick_o is high while the count sits at TICK_DIV-1.
module clint_prescaler
    import clint_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned        CNT_W    = 16;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end

    // tick_o is registered alongside the count so it always mirrors (cnt == CNT_LAST)
    always_ff @(posedge clk_i) begin
        if (rst_i == RESET_ENABLE) begin
            cnt    <= '0;
            tick_o <= (CNT_LAST == '0);
        end else begin
            cnt    <= cnt_nxt;
            tick_o <= (cnt_nxt == CNT_LAST);
        end
    end

endmodule

// File: rtl/clint_timer.sv
// Machine-mode CLINT: mtime/mtimecmp/msip behind a single-cycle register port, registered mip outputs.
// Optional CLINT_MTIME_SNAPSHOT_EN: an MTIME_LO read latches mtime[63:32] for the following MTIME_HI read.
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [REG_W-1:0]      wdata_i,
    output logic [REG_W-1:0]      rdata_o,
    output logic                  ack_o,
    output logic                  mip_timer_o,
    output logic                  mip_sw_o
);

    logic              tick;
    logic [TIME_W-1:0] mtime;
    logic [TIME_W-1:0] mtime_nxt;
    logic [TIME_W-1:0] mtimecmp;
    logic [TIME_W-1:0] mtimecmp_nxt;
    logic              msip;
    logic              msip_nxt;
    logic [ADDR_WIDTH-1:0] word_addr;
    reg_sel_e          sel;
    logic              wr;
    logic              rd;
    logic [REG_W-1:0]  rdata_nxt;

    clint_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (tick)
    );

    // Offset decode; the low two address bits never select a register
    always_comb begin
        word_addr = addr_i & ~ADDR_WIDTH'(3);
        sel       = REG_NONE;
        if (word_addr == ADDR_WIDTH'(CLINT_MSIP))             sel = REG_MSIP;
        else if (word_addr == ADDR_WIDTH'(CLINT_MTIMECMP_LO)) sel = REG_CMP_LO;
        else if (word_addr == ADDR_WIDTH'(CLINT_MTIMECMP_HI)) sel = REG_CMP_HI;
        else if (word_addr == ADDR_WIDTH'(CLINT_MTIME_LO))    sel = REG_TIME_LO;
        else if (word_addr == ADDR_WIDTH'(CLINT_MTIME_HI))    sel = REG_TIME_HI;
        wr = req_i && we_i;
        rd = req_i && !we_i;
    end

`ifdef CLINT_MTIME_SNAPSHOT_EN
    logic [REG_W-1:0] mtime_hi_shadow;

    always_ff @(posedge clk_i) begin
        if (rst_i == RESET_ENABLE) begin
            mtime_hi_shadow <= '0;
        end else if (rd && (sel == REG_TIME_LO)) begin
            mtime_hi_shadow <= mtime[TIME_W-1:REG_W];
        end
    end
`endif

    always_comb begin
        rdata_nxt = '0;
        unique case (sel)
            REG_MSIP:    rdata_nxt = REG_W'(msip);
            REG_CMP_LO:  rdata_nxt = mtimecmp[REG_W-1:0];
            REG_CMP_HI:  rdata_nxt = mtimecmp[TIME_W-1:REG_W];
            REG_TIME_LO: rdata_nxt = mtime[REG_W-1:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
            REG_TIME_HI: rdata_nxt = mtime_hi_shadow;
`else
            REG_TIME_HI: rdata_nxt = mtime[TIME_W-1:REG_W];
`endif
            default:     rdata_nxt = '0;
        endcase
    end

    // A bus write to either mtime half overrides that cycle's tick
    always_comb begin
        mtime_nxt    = mtime;
        mtimecmp_nxt = mtimecmp;
        msip_nxt     = msip;
        if (wr && (sel == REG_TIME_LO))      mtime_nxt[REG_W-1:0]      = wdata_i;
        else if (wr && (sel == REG_TIME_HI)) mtime_nxt[TIME_W-1:REG_W] = wdata_i;
        else if (tick)                       mtime_nxt                 = mtime + TIME_W'(1);
        if (wr && (sel == REG_CMP_LO)) mtimecmp_nxt[REG_W-1:0]      = wdata_i;
        if (wr && (sel == REG_CMP_HI)) mtimecmp_nxt[TIME_W-1:REG_W] = wdata_i;
        if (wr && (sel == REG_MSIP))   msip_nxt                     = wdata_i[0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i == RESET_ENABLE) begin
            mtime       <= '0;
            mtimecmp    <= MTIMECMP_RST;
            msip        <= 1'b0;
            ack_o       <= 1'b0;
            rdata_o     <= '0;
            mip_timer_o <= 1'b0;
            mip_sw_o    <= 1'b0;
        end else begin
            mtime       <= mtime_nxt;
            mtimecmp    <= mtimecmp_nxt;
            msip        <= msip_nxt;
            ack_o       <= req_i;
            rdata_o     <= rd ? rdata_nxt : '0;
            mip_timer_o <= (mtime >= mtimecmp);
            // msip_nxt so the software interrupt rises together with the write ack
            mip_sw_o    <= msip_nxt;
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer (TICK_DIV 1 and 4) and clint_prescaler (TICK_DIV 1 and 3).
module tb_clint_timer;
    import clint_timer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, we0, ack0, mt0, ms0;
    logic [15:0] addr0;
    logic [31:0] wd0, rd0;
    logic        req1, we1, ack1, mt1, ms1;
    logic [15:0] addr1;
    logic [31:0] wd1, rd1;
    logic        tick_p1, tick_p3;

    clint_timer #(.TICK_DIV(1), .ADDR_WIDTH(16)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we0), .addr_i(addr0), .wdata_i(wd0),
        .rdata_o(rd0), .ack_o(ack0), .mip_timer_o(mt0), .mip_sw_o(ms0));

    clint_timer #(.TICK_DIV(4), .ADDR_WIDTH(16)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1), .wdata_i(wd1),
        .rdata_o(rd1), .ack_o(ack1), .mip_timer_o(mt1), .mip_sw_o(ms1));

    clint_prescaler #(.TICK_DIV(1)) u_pre1 (.clk_i(clk), .rst_i(rst), .tick_o(tick_p1));
    clint_prescaler #(.TICK_DIV(3)) u_pre3 (.clk_i(clk), .rst_i(rst), .tick_o(tick_p3));

    typedef struct {
        int unsigned cyc;
        bit          chk;
        logic [31:0] data;
        string       tag;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    // Reference state: mtime = anc_v + ticks since anc_k, ticks land on edges k with k % div == 0
    int unsigned dv[2] = '{1, 4};
    logic [63:0] anc_v[2];
    int unsigned anc_k[2];
    logic [63:0] cmp_m[2];
    logic        msip_m[2];
    logic [31:0] shadow_m[2];

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            anc_v[i]    = 64'd0;
            anc_k[i]    = 0;
            cmp_m[i]    = 64'hFFFF_FFFF_FFFF_FFFF;
            msip_m[i]   = 1'b0;
            shadow_m[i] = 32'd0;
        end
    endtask

    function automatic logic [63:0] mt(input int s);
        return anc_v[s] + 64'(cyc / dv[s]) - 64'(anc_k[s] / dv[s]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_bus(input int s, input logic ack, input logic [31:0] rdata);
        exp_t e;
        bit   due;
        if (s == 0) due = (sb0.size() > 0) && (sb0[0].cyc == cyc);
        else        due = (sb1.size() > 0) && (sb1[0].cyc == cyc);
        if (due) begin
            if (s == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            chk({e.tag, "/ack"}, 64'(ack), 64'd1);
            if (e.chk) chk(e.tag, 64'(rdata), 64'(e.data));
        end else begin
            chk((s == 0) ? "idle_ack0" : "idle_ack1", 64'(ack), 64'd0);
            chk((s == 0) ? "idle_rdata0" : "idle_rdata1", 64'(rdata), 64'd0);
        end
    endtask

    // One clock: inputs settle at negedge, outputs are checked at the next negedge
    task automatic cycle();
        logic rst_now, et0, et1;
        rst_now = rst;
        et0 = !rst_now && (mt(0) >= cmp_m[0]);
        et1 = !rst_now && (mt(1) >= cmp_m[1]);
        @(posedge clk);
        if (rst_now) begin
            cyc = 0;
            reset_model();
        end else begin
            cyc++;
        end
        @(negedge clk);
        check_bus(0, ack0, rd0);
        check_bus(1, ack1, rd1);
        chk("mip_timer0", 64'(mt0), 64'(et0));
        chk("mip_timer4", 64'(mt1), 64'(et1));
        chk("mip_sw0", 64'(ms0), 64'(msip_m[0]));
        chk("mip_sw4", 64'(ms1), 64'(msip_m[1]));
        chk("pre1_tick", 64'(tick_p1), 64'd1);
        chk("pre3_tick", 64'(tick_p3), 64'((cyc % 3) == 2));
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic access(input int s, input logic w, input logic [15:0] a,
                          input logic [31:0] d, input string tag);
        logic [63:0] cur;
        logic [31:0] ex;
        logic [15:0] wa;
        exp_t        e;
        cur = mt(s);
        wa  = a & 16'hFFFC;
        case (wa)
            CLINT_MSIP:        ex = {31'd0, msip_m[s]};
            CLINT_MTIMECMP_LO: ex = cmp_m[s][31:0];
            CLINT_MTIMECMP_HI: ex = cmp_m[s][63:32];
            CLINT_MTIME_LO:    ex = cur[31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
            CLINT_MTIME_HI:    ex = shadow_m[s];
`else
            CLINT_MTIME_HI:    ex = cur[63:32];
`endif
            default:           ex = 32'd0;
        endcase
        e.cyc = cyc + 1; e.chk = !w; e.data = ex; e.tag = tag;
        if (s == 0) begin
            sb0.push_back(e);
            req0 = 1'b1; we0 = w; addr0 = a; wd0 = d;
        end else begin
            sb1.push_back(e);
            req1 = 1'b1; we1 = w; addr1 = a; wd1 = d;
        end
        if (w && wa == CLINT_MSIP) msip_m[s] = d[0];
        if (!w && wa == CLINT_MTIME_LO) shadow_m[s] = cur[63:32];
        cycle();
        req0 = 1'b0; we0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
        if (w) begin
            case (wa)
                CLINT_MTIMECMP_LO: cmp_m[s][31:0]  = d;
                CLINT_MTIMECMP_HI: cmp_m[s][63:32] = d;
                CLINT_MTIME_LO: begin anc_v[s] = {cur[63:32], d}; anc_k[s] = cyc; end
                CLINT_MTIME_HI: begin anc_v[s] = {d, cur[31:0]};  anc_k[s] = cyc; end
                default: ;
            endcase
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = 16'd0; wd0 = 32'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 16'd0; wd1 = 32'd0;
        reset_model();
        idle(3);
        rst = 1'b0;

        // Free-running count from reset, then compare against mtimecmp = 20
        idle(10);
        access(0, 1'b0, CLINT_MTIME_LO, 32'd0, "mtime_lo_after_reset");
        access(1, 1'b0, CLINT_MTIMECMP_HI, 32'd0, "cmp_hi_reset4");
        access(0, 1'b1, CLINT_MTIMECMP_HI, 32'd0, "w_cmp_hi");
        access(0, 1'b1, CLINT_MTIMECMP_LO, 32'd20, "w_cmp_lo");
        access(0, 1'b0, CLINT_MTIMECMP_LO, 32'd0, "cmp_lo_rb");
        idle(15);
        access(0, 1'b1, CLINT_MTIMECMP_LO, 32'hFFFF_FFFF, "w_cmp_lo_max");
        idle(3);

        // Software interrupt bit
        access(0, 1'b1, CLINT_MSIP, 32'hFFFF_FFFF, "w_msip_ones");
        access(0, 1'b0, 16'h0002, 32'd0, "msip_rb");
        access(0, 1'b1, CLINT_MSIP, 32'd0, "w_msip_zero");
        access(0, 1'b0, CLINT_MSIP, 32'd0, "msip_rb_zero");
        idle(2);

        // 64-bit wrap, then compare at mtime = 5
        access(0, 1'b1, CLINT_MTIME_HI, 32'hFFFF_FFFF, "w_mtime_hi");
        access(0, 1'b1, CLINT_MTIME_LO, 32'hFFFF_FFFE, "w_mtime_lo");
        access(0, 1'b1, CLINT_MTIMECMP_LO, 32'd5, "w_cmp_lo5");
        access(0, 1'b0, CLINT_MTIME_HI, 32'd0, "mtime_hi_prewrap");
        access(0, 1'b0, CLINT_MTIME_LO, 32'd0, "mtime_lo_wrap");
        access(0, 1'b0, CLINT_MTIME_HI, 32'd0, "mtime_hi_wrap");
        idle(8);

        // Carry between halves right after a LO read
        access(0, 1'b1, CLINT_MTIME_HI, 32'd0, "w_mtime_hi0");
        access(0, 1'b1, CLINT_MTIME_LO, 32'hFFFF_FFFF, "w_mtime_lo_max");
        access(0, 1'b0, CLINT_MTIME_LO, 32'd0, "carry_lo");
        access(0, 1'b0, CLINT_MTIME_HI, 32'd0, "carry_hi");
        access(0, 1'b0, CLINT_MTIME_HI, 32'd0, "carry_hi_again");

        // TICK_DIV = 4: write landing on a tick edge, then hold for four reads
        while (((cyc + 1) % 4) != 0) cycle();
        access(1, 1'b1, CLINT_MTIME_LO, 32'h1234_5678, "w_mtlo_on_tick");
        for (int i = 0; i < 6; i++) access(1, 1'b0, CLINT_MTIME_LO, 32'd0, "mtlo_hold");
        access(1, 1'b0, 16'h1234, 32'd0, "unmapped_rd");
        access(1, 1'b1, 16'h1234, 32'hDEAD_BEEF, "unmapped_wr");
        access(1, 1'b0, CLINT_MSIP, 32'd0, "msip4_rb");
        access(1, 1'b0, CLINT_MTIME_HI, 32'd0, "mthi4_rb");

        // Reset mid-access drops the ack and clears state
        access(0, 1'b1, CLINT_MSIP, 32'd1, "w_msip_pre_rst");
        req0 = 1'b1; we0 = 1'b0; addr0 = CLINT_MTIME_LO;
        rst = 1'b1;
        cycle();
        req0 = 1'b0;
        rst = 1'b0;
        idle(2);
        access(0, 1'b0, CLINT_MTIME_LO, 32'd0, "mtime_lo_post_rst");
        access(0, 1'b0, CLINT_MTIMECMP_LO, 32'd0, "cmp_lo_post_rst");
        access(0, 1'b0, CLINT_MSIP, 32'd0, "msip_post_rst");
        idle(2);

        chk("sb0_drained", 64'(sb0.size()), 64'd0);
        chk("sb1_drained", 64'(sb1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
